// File: rtl/mux8_sched.sv
// Round-robin scheduler sharing one 8:1 single-bit mux among eight requesters; registered grant/select/data.
// Optional grant extension via `define MUX8_SCHED_LOCK_EN (lock port always present, ignored when undefined).
module mux8_sched #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       lock,
  input  logic [7:0] din,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       gnt_new,
  output logic       dout
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    ptr;

  logic          lock_hold;
  logic          hold;
  logic [2:0]    base;
  logic [2:0]    win;
  logic          found;

`ifdef MUX8_SCHED_LOCK_EN
  assign lock_hold = lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold   = 1'b0;
`endif

  assign hold = (state == GRANT) && req[sel] && ((cnt < CNT_MAX) || lock_hold);

  // At a release edge the departing owner becomes the new last-owner pointer.
  assign base = (state == GRANT) ? sel : ptr;

  always_comb begin
    found = 1'b0;
    win   = base;
    for (int i = 1; i <= 8; i++) begin
      if (!found && req[base + 3'(i)]) begin
        found = 1'b1;
        win   = base + 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= 3'd7;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      gnt_new <= 1'b0;
      dout    <= 1'b0;
    end else if (hold) begin
      // Under lock the count saturates so the limit bites as soon as lock falls.
      if (cnt < CNT_MAX) cnt <= cnt + CNT_ONE;
      gnt_new <= 1'b0;
      dout    <= din[sel];
    end else begin
      if (state == GRANT) ptr <= sel;
      if (found) begin
        state   <= GRANT;
        cnt     <= CNT_ONE;
        gnt     <= 8'(1) << win;
        sel     <= win;
        busy    <= 1'b1;
        gnt_new <= 1'b1;
        dout    <= din[win];
      end else begin
        state   <= IDLE;
        cnt     <= '0;
        gnt     <= '0;
        busy    <= 1'b0;
        gnt_new <= 1'b0;
        dout    <= 1'b0;
      end
    end
  end

endmodule
